wb_button_master: RTL and testbench

Wishbone B4 classic single-access master that turns user button presses into read-modify-write transactions on an 8-bit LED register. It sits in the user project next to the button/LED slave and drives that slave's bus. Buttons are synchronised and debounced, and each press is queued. Every queued batch becomes one read followed by one write.

---
 rtl/wb_button_master.sv | 182 ++++++++++++++++++
 tb/tb_wb_button_master.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_button_master.sv
// Wishbone B4 classic single-access master. Debounced button presses are
// queued and each queued batch becomes one read-modify-write of an 8-bit
// LED register: button0/button1 toggle LED0/LED1, button2 clears all LEDs.
module wb_button_master #(
    parameter logic [31:0] LED_ADDR        = 32'h3000_0000,
    parameter int          DEBOUNCE_CYCLES = 1000,
    parameter int          TIMEOUT_CYCLES  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [2:0]  buttons,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        err_timeout
);

    localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        GAP   = 2'd2,
        WRITE = 2'd3
    } state_t;

    // One-cycle pulse per button on the edge its debounced level goes 0->1.
    logic [2:0] press;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            deb_reg;
            logic [DB_W-1:0] cnt_reg;
            logic            differ;

            assign differ    = (sync2_reg != deb_reg);
            // The last differing sample before acceptance is the one that
            // flips the debounced level, so the press pulse uses it.
            assign press[gi] = differ && (cnt_reg == DB_LAST) && sync2_reg;

            // Synchronise the raw level, then accept it only after it has
            // differed from the debounced level for DEBOUNCE_CYCLES samples.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= buttons[gi];
                    sync2_reg <= sync1_reg;
                    if (!differ) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    state_t          state_reg, state_next;
    logic [2:0]      pending_reg, pending_next;
    logic [2:0]      snap_reg, snap_next;
    logic [7:0]      rdata_reg, rdata_next;
    logic [TO_W-1:0] tmo_reg, tmo_next;
    logic            err_reg, err_next;
    logic [2:0]      pending_clr;
    logic [7:0]      wval;
    logic [23:0]     dat_i_unused;

    // Only the low byte of the LED register is meaningful.
    assign dat_i_unused = wbm_dat_i[31:8];

    // Button2 clears everything; otherwise buttons 0/1 toggle their LED.
    assign wval = snap_reg[2] ? 8'h00 : (rdata_reg ^ {6'b0, snap_reg[1:0]});

    // Transaction sequencing, timeout and bus outputs.
    always_comb begin
        state_next  = state_reg;
        snap_next   = snap_reg;
        rdata_next  = rdata_reg;
        tmo_next    = tmo_reg;
        err_next    = err_reg;
        pending_clr = 3'b000;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_we_o    = 1'b0;
        wbm_sel_o   = 4'h0;
        wbm_adr_o   = 32'h0;
        wbm_dat_o   = 32'h0;

        case (state_reg)
            IDLE: begin
                if (pending_reg != 3'b000) begin
                    snap_next   = pending_reg;
                    pending_clr = pending_reg;
                    tmo_next    = '0;
                    state_next  = READ;
                end
            end
            READ: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_sel_o = 4'hF;
                wbm_adr_o = LED_ADDR;
                if (wbm_ack_i) begin
                    rdata_next = wbm_dat_i[7:0];
                    state_next = GAP;
                end else if (tmo_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    snap_next  = 3'b000;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            GAP: begin
                tmo_next   = '0;
                state_next = WRITE;
            end
            WRITE: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_sel_o = 4'hF;
                wbm_adr_o = LED_ADDR;
                wbm_dat_o = {24'h0, wval};
                if (wbm_ack_i) begin
                    state_next = IDLE;
                end else if (tmo_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    snap_next  = 3'b000;
                    state_next = IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A new press wins over a clear of the same bit on the same edge.
        pending_next = (pending_reg & ~pending_clr) | press;
    end

    assign busy        = (state_reg != IDLE);
    assign err_timeout = err_reg;

    // State registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            pending_reg <= 3'b000;
            snap_reg    <= 3'b000;
            rdata_reg   <= 8'h00;
            tmo_reg     <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            snap_reg    <= snap_next;
            rdata_reg   <= rdata_next;
            tmo_reg     <= tmo_next;
            err_reg     <= err_next;
        end
    end

endmodule

// File: tb/tb_wb_button_master.sv
// Directed bench for wb_button_master: the bench acts as the LED slave and
// checks every bus phase against hand-computed values.
module tb_wb_button_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  buttons;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy, err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_button_master #(
        .LED_ADDR        (32'h3000_0000),
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .buttons     (buttons),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Count cycles with any bus activity over a window; expect none.
    task automatic quiet(input string tag, input int n);
        int active;
        active = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (wbm_cyc_o || wbm_stb_o || busy) active++;
        end
        check_eq(tag, active, 0);
    endtask

    // Wait (bounded) for cyc; lat = rising edges from call to cyc observed.
    task automatic wait_cyc(input string tag, output int lat, output bit seen);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wbm_cyc_o && lat < 100);
        seen = wbm_cyc_o;
        check_eq({tag, "_cyc_seen"}, {31'b0, seen}, 1);
    endtask

    // Serve one read (returning rd) and check the following gap and write.
    task automatic do_txn(input string tag, input logic [7:0] rd, input logic [7:0] wr, output int lat);
        bit seen;
        wait_cyc(tag, lat, seen);
        if (!seen) return;
        check_eq({tag, "_rd_we"},   {31'b0, wbm_we_o}, 0);
        check_eq({tag, "_rd_sel"},  {28'b0, wbm_sel_o}, 32'hF);
        check_eq({tag, "_rd_adr"},  wbm_adr_o, 32'h3000_0000);
        check_eq({tag, "_rd_busy"}, {31'b0, busy}, 1);
        @(negedge clk);
        check_eq({tag, "_rd_stb_hold"}, {31'b0, wbm_stb_o}, 1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = {24'h0, rd};
        @(negedge clk);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hDEAD_BE5A;
        check_eq({tag, "_gap_cyc"}, {31'b0, wbm_cyc_o}, 0);
        @(negedge clk);
        check_eq({tag, "_wr_cyc"}, {31'b0, wbm_cyc_o}, 1);
        check_eq({tag, "_wr_we"},  {31'b0, wbm_we_o}, 1);
        check_eq({tag, "_wr_adr"}, wbm_adr_o, 32'h3000_0000);
        check_eq({tag, "_wr_dat"}, wbm_dat_o, {24'h0, wr});
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        check_eq({tag, "_end_cyc"},  {31'b0, wbm_cyc_o}, 0);
        check_eq({tag, "_end_busy"}, {31'b0, busy}, 0);
    endtask

    initial begin
        int  lat, n, bad;
        bit  seen;

        rst       = 1'b1;
        buttons   = 3'b000;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("reset_cyc",  {31'b0, wbm_cyc_o}, 0);
        check_eq("reset_busy", {31'b0, busy}, 0);
        check_eq("reset_err",  {31'b0, err_timeout}, 0);
        rst = 1'b0;

        // 1: idle with buttons released, nothing moves.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wbm_cyc_o || wbm_stb_o || wbm_we_o || busy || err_timeout ||
                wbm_adr_o != 32'h0 || wbm_dat_o != 32'h0) bad++;
        end
        check_eq("idle_200", bad, 0);

        // 2: button0 toggles LED0: A5 -> A4, with 7-8 edge latency.
        buttons = 3'b001;
        do_txn("t2", 8'hA5, 8'hA4, lat);
        check_eq("t2_latency_7_8", {31'b0, (lat >= 7 && lat <= 8)}, 1);
        buttons = 3'b000;
        quiet("t2_single", 20);

        // 3: glitch shorter than the debounce window is rejected.
        buttons = 3'b010;
        repeat (3) @(negedge clk);
        buttons = 3'b000;
        quiet("t3_glitch", 50);

        // 4: simultaneous presses merge; button2 clears.
        buttons = 3'b011;
        do_txn("t4a", 8'h0F, 8'h0C, lat);
        buttons = 3'b000;
        quiet("t4a_single", 20);
        buttons = 3'b100;
        do_txn("t4b", 8'hFF, 8'h00, lat);
        buttons = 3'b000;
        quiet("t4b_single", 20);

        // 5: unanswered read times out after 8 cycles, no write follows.
        buttons = 3'b001;
        wait_cyc("t5", lat, seen);
        check_eq("t5_err_before", {31'b0, err_timeout}, 0);
        n = 0;
        while (wbm_cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_cyc_len", n, 8);
        check_eq("t5_err_set", {31'b0, err_timeout}, 1);
        quiet("t5_no_write", 30);
        buttons = 3'b000;
        repeat (20) @(negedge clk);
        buttons = 3'b010;
        do_txn("t5b", 8'h00, 8'h02, lat);
        check_eq("t5_err_sticky", {31'b0, err_timeout}, 1);
        buttons = 3'b000;
        repeat (20) @(negedge clk);

        // 6: reset while WRITE waits for ack.
        buttons = 3'b001;
        wait_cyc("t6", lat, seen);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0000_0001;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        @(negedge clk);
        check_eq("t6_in_write", {31'b0, wbm_we_o}, 1);
        rst     = 1'b1;
        buttons = 3'b000;
        @(negedge clk);
        check_eq("t6_rst_cyc",  {31'b0, wbm_cyc_o}, 0);
        check_eq("t6_rst_stb",  {31'b0, wbm_stb_o}, 0);
        check_eq("t6_rst_we",   {31'b0, wbm_we_o}, 0);
        check_eq("t6_rst_busy", {31'b0, busy}, 0);
        check_eq("t6_rst_err",  {31'b0, err_timeout}, 0);
        check_eq("t6_rst_dat",  wbm_dat_o, 0);
        rst = 1'b0;
        quiet("t6_after", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
